// File: rtl/fpu_arbiter.sv
// ---------------------------------------------------------------------------
// fpu_arbiter
//
// Shares one fixed-latency FPU between NREQ requesters. A rotating-priority
// arbiter picks one requester per cycle, the chosen operation is issued to
// the FPU on the following cycle, and a tag pipeline remembers who owns each
// in-flight operation. The result is routed back to that requester when it
// emerges from the FPU LAT cycles after issue.
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst         synchronous active-high reset
//   req_valid   per-requester request
//   req_ready   one-hot grant (accepted when req_valid & req_ready)
//   req_op      opcodes, requester i at [i*OPW +: OPW]
//   req_a/b     operands, requester i at [i*W +: W]
//   fpu_valid   issue strobe to the FPU
//   fpu_op/a/b  issued opcode and operands
//   fpu_res     FPU result, valid LAT cycles after the matching fpu_valid
//   resp_valid  one-hot result strobe to the owning requester
//   resp_data   result data shared by all requesters
// ---------------------------------------------------------------------------
module fpu_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 32,
    parameter int LAT  = 3,
    parameter int OPW  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*OPW-1:0] req_op,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    output logic                fpu_valid,
    output logic [OPW-1:0]      fpu_op,
    output logic [W-1:0]        fpu_a,
    output logic [W-1:0]        fpu_b,
    input  logic [W-1:0]        fpu_res,
    output logic [NREQ-1:0]     resp_valid,
    output logic [W-1:0]        resp_data
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Priority pointer: index of the most recent winner
    logic [IDW-1:0]  ptr_q, ptr_d;

    // Registered issue stage feeding the FPU
    logic            issueValid_q, issueValid_d;
    logic [OPW-1:0]  issueOp_q, issueOp_d;
    logic [W-1:0]    issueA_q, issueA_d;
    logic [W-1:0]    issueB_q, issueB_d;
    logic [IDW-1:0]  issueId_q, issueId_d;

    // In-flight tag pipeline, stage LAT-1 lines up with fpu_res
    logic [LAT-1:0]  tagValid_q, tagValid_d;
    logic [IDW-1:0]  tagId_q [LAT];
    logic [IDW-1:0]  tagId_d [LAT];

    // Arbitration results
    logic            grantValid;
    logic [IDW-1:0]  grantIdx;
    logic            lowHit;
    logic [IDW-1:0]  lowIdx;
    logic            anyHit;
    logic [IDW-1:0]  anyIdx;

    // Rotating priority: scan upwards so the last hit is the highest index.
    // Prefer the highest valid index below the pointer; if there is none,
    // wrap around and take the highest valid index overall. A pointer of 0
    // therefore always selects the highest valid requester. No grant is
    // given while reset is asserted.
    always_comb begin
        lowHit = 1'b0;
        lowIdx = '0;
        anyHit = 1'b0;
        anyIdx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i]) begin
                anyHit = 1'b1;
                anyIdx = IDW'(i);
                if (i < int'(ptr_q)) begin
                    lowHit = 1'b1;
                    lowIdx = IDW'(i);
                end
            end
        end
        grantValid = anyHit & ~rst;
        grantIdx   = lowHit ? lowIdx : anyIdx;
        req_ready  = grantValid ? (NREQ'(1) << grantIdx) : '0;
    end

    // Next-state for the pointer and the issue stage. The winner's opcode
    // and operands are captured at the grant edge; with no grant the issue
    // registers keep their old contents and only the valid bit drops.
    always_comb begin
        ptr_d        = ptr_q;
        issueValid_d = grantValid;
        issueOp_d    = issueOp_q;
        issueA_d     = issueA_q;
        issueB_d     = issueB_q;
        issueId_d    = issueId_q;
        if (grantValid) begin
            ptr_d     = grantIdx;
            issueOp_d = req_op[grantIdx*OPW +: OPW];
            issueA_d  = req_a[grantIdx*W +: W];
            issueB_d  = req_b[grantIdx*W +: W];
            issueId_d = grantIdx;
        end
    end

    // Tag pipeline next-state: stage 0 records whatever is being issued
    // this cycle, every other stage takes its predecessor.
    always_comb begin
        tagValid_d    = '0;
        tagValid_d[0] = issueValid_q;
        tagId_d[0]    = issueId_q;
        for (int k = 1; k < LAT; k++) begin
            tagValid_d[k] = tagValid_q[k-1];
            tagId_d[k]    = tagId_q[k-1];
        end
    end

    // Control state with synchronous reset. Clearing the tag valids here is
    // what discards in-flight operations when reset hits mid-stream.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q        <= '0;
            issueValid_q <= 1'b0;
            issueOp_q    <= '0;
            issueA_q     <= '0;
            issueB_q     <= '0;
            tagValid_q   <= '0;
        end else begin
            ptr_q        <= ptr_d;
            issueValid_q <= issueValid_d;
            issueOp_q    <= issueOp_d;
            issueA_q     <= issueA_d;
            issueB_q     <= issueB_d;
            tagValid_q   <= tagValid_d;
        end
    end

    // Owner ids are only meaningful alongside their valid bits, so they
    // need no reset.
    always_ff @(posedge clk) begin
        issueId_q <= issueId_d;
        for (int k = 0; k < LAT; k++) begin
            tagId_q[k] <= tagId_d[k];
        end
    end

    // FPU-facing outputs are forced quiet during the reset cycle itself so
    // an issue registered just before reset is not presented.
    always_comb begin
        fpu_valid = issueValid_q & ~rst;
        fpu_op    = rst ? '0 : issueOp_q;
        fpu_a     = rst ? '0 : issueA_q;
        fpu_b     = rst ? '0 : issueB_q;
    end

    // Response routing: the last tag stage coincides with the FPU result,
    // so the result is passed straight through to its owner.
    always_comb begin
        resp_valid = '0;
        if (tagValid_q[LAT-1] && !rst) begin
            resp_valid = NREQ'(1) << tagId_q[LAT-1];
        end
        resp_data = fpu_res;
    end

endmodule

// File: tb/tb_fpu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fpu_arbiter
//
// Directed bench for fpu_arbiter with a behavioural fixed-latency FPU, plus
// a sparse random-traffic phase tracked by an in-order scoreboard.
// ---------------------------------------------------------------------------
module tb_fpu_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 32;
    localparam int LAT  = 3;
    localparam int OPW  = 2;

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*OPW-1:0] req_op;
    logic [NREQ*W-1:0]   req_a;
    logic [NREQ*W-1:0]   req_b;
    logic                fpu_valid;
    logic [OPW-1:0]      fpu_op;
    logic [W-1:0]        fpu_a;
    logic [W-1:0]        fpu_b;
    logic [W-1:0]        fpu_res;
    logic [NREQ-1:0]     resp_valid;
    logic [W-1:0]        resp_data;

    int checks = 0;
    int errors = 0;

    // Random-phase bookkeeping
    logic [NREQ-1:0] pending;
    int              waitCnt [NREQ];
    int              maxWait;
    int              expId [$];
    logic [W-1:0]    expDat [$];

    fpu_arbiter #(
        .NREQ(NREQ),
        .W   (W),
        .LAT (LAT),
        .OPW (OPW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .fpu_valid (fpu_valid),
        .fpu_op    (fpu_op),
        .fpu_a     (fpu_a),
        .fpu_b     (fpu_b),
        .fpu_res   (fpu_res),
        .resp_valid(resp_valid),
        .resp_data (resp_data)
    );

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in FPU arithmetic: simple integer ops keyed by opcode
    function automatic logic [W-1:0] fpuModel(input logic [OPW-1:0] op,
                                              input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a * b;
            default: return a ^ b;
        endcase
    endfunction

    // Fixed-latency FPU: samples its inputs every edge and presents the
    // result LAT cycles later. It keeps running through reset on purpose,
    // so stale results still show up on fpu_res afterwards.
    logic [W-1:0] fpuPipe [LAT];
    always @(posedge clk) begin
        fpuPipe[0] <= fpuModel(fpu_op, fpu_a, fpu_b);
        for (int k = 1; k < LAT; k++) begin
            fpuPipe[k] <= fpuPipe[k-1];
        end
    end
    assign fpu_res = fpuPipe[LAT-1];

    // Safety net so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single comparison point, counted and reported on failure
    task automatic checkOutput(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] v);
        req_valid = v;
    endtask

    task automatic setReq(input int i, input logic [OPW-1:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b);
        req_op[i*OPW +: OPW] = op;
        req_a[i*W +: W]      = a;
        req_b[i*W +: W]      = b;
    endtask

    // Random-phase monitor for one cycle: grant legality, scoreboard push
    // on accept, fairness bookkeeping, and in-order response matching.
    task automatic sampleCycle();
        int g;
        int qid;
        logic [W-1:0] qdat;
        logic legal;
        legal = $onehot0(req_ready) && ((req_ready & ~req_valid) == '0);
        checkOutput("grant_legal", {63'd0, legal}, 64'd1);
        if (req_ready != '0) begin
            g = 0;
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
            expId.push_back(g);
            expDat.push_back(fpuModel(req_op[g*OPW +: OPW], req_a[g*W +: W],
                                      req_b[g*W +: W]));
            for (int j = 0; j < NREQ; j++) begin
                if (j != g && pending[j]) begin
                    waitCnt[j]++;
                    if (waitCnt[j] > maxWait) maxWait = waitCnt[j];
                end
            end
            waitCnt[g]  = 0;
            pending[g]  = 1'b0;
        end
        if (resp_valid != '0) begin
            if (expId.size() == 0) begin
                checkOutput("resp_unexpected", {60'd0, resp_valid}, 64'd0);
            end else begin
                qid  = expId.pop_front();
                qdat = expDat.pop_front();
                checkOutput("resp_id", {60'd0, resp_valid},
                            64'(NREQ'(1) << qid));
                checkOutput("resp_data", {32'd0, resp_data}, {32'd0, qdat});
            end
        end
    endtask

    // Expected tables for the all-requesting burst
    logic [NREQ-1:0] burstReady [9];
    logic [NREQ-1:0] burstResp  [9];
    logic [W-1:0]    burstData  [9];

    // Directed steps followed by the random phase, all in one thread
    initial begin
        burstReady = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000,
                       4'b0000, 4'b0000, 4'b0000, 4'b0000};
        burstResp  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000,
                       4'b0100, 4'b0010, 4'b0001, 4'b1000};
        burstData  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFF,
                       32'h2A, 32'h5, 32'h8, 32'hFF};

        rst       = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        pending   = '0;
        maxWait   = 0;
        for (int i = 0; i < NREQ; i++) waitCnt[i] = 0;

        // Reset state, with requests present that must not be granted
        tick();
        tick();
        applyStimulus(4'b1111);
        #2;
        checkOutput("reset_ready", {60'd0, req_ready}, 64'd0);
        checkOutput("reset_fpu_valid", {63'd0, fpu_valid}, 64'd0);
        checkOutput("reset_resp_valid", {60'd0, resp_valid}, 64'd0);
        checkOutput("reset_fpu_a", {32'd0, fpu_a}, 64'd0);

        // Single request: 1.0 + 2.0 from requester 0
        tick();
        rst = 1'b0;
        setReq(0, 2'd0, 32'h3F80_0000, 32'h4000_0000);
        applyStimulus(4'b0001);
        #2;
        checkOutput("single_grant", {60'd0, req_ready}, 64'b0001);
        tick();
        applyStimulus(4'b0000);
        #2;
        checkOutput("single_fpu_valid", {63'd0, fpu_valid}, 64'd1);
        checkOutput("single_fpu_op", {62'd0, fpu_op}, 64'd0);
        checkOutput("single_fpu_a", {32'd0, fpu_a}, 64'h3F80_0000);
        checkOutput("single_fpu_b", {32'd0, fpu_b}, 64'h4000_0000);
        checkOutput("single_no_regrant", {60'd0, req_ready}, 64'd0);
        tick();
        #2;
        checkOutput("single_resp_t2", {60'd0, resp_valid}, 64'd0);
        checkOutput("single_fpu_idle", {63'd0, fpu_valid}, 64'd0);
        tick();
        #2;
        checkOutput("single_resp_t3", {60'd0, resp_valid}, 64'd0);
        tick();
        #2;
        checkOutput("single_resp_t4", {60'd0, resp_valid}, 64'b0001);
        checkOutput("single_resp_data", {32'd0, resp_data}, 64'h7F80_0000);
        tick();
        #2;
        checkOutput("single_resp_t5", {60'd0, resp_valid}, 64'd0);

        // All requesting: grants rotate 3,2,1,0,3 and results follow
        tick();
        setReq(0, 2'd0, 32'd5, 32'd3);
        setReq(1, 2'd1, 32'd9, 32'd4);
        setReq(2, 2'd2, 32'd6, 32'd7);
        setReq(3, 2'd3, 32'hF0, 32'h0F);
        for (int c = 0; c < 9; c++) begin
            applyStimulus(c < 5 ? 4'b1111 : 4'b0000);
            #2;
            checkOutput($sformatf("burst_ready_c%0d", c),
                        {60'd0, req_ready}, {60'd0, burstReady[c]});
            checkOutput($sformatf("burst_resp_c%0d", c),
                        {60'd0, resp_valid}, {60'd0, burstResp[c]});
            if (burstResp[c] != '0) begin
                checkOutput($sformatf("burst_data_c%0d", c),
                            {32'd0, resp_data}, {32'd0, burstData[c]});
            end
            tick();
        end

        // Pointer wrap: pointer is 3, grant 1; then 1010 -> 3, then -> 1
        applyStimulus(4'b0010);
        #2;
        checkOutput("wrap_setup", {60'd0, req_ready}, 64'b0010);
        tick();
        applyStimulus(4'b1010);
        #2;
        checkOutput("wrap_grant3", {60'd0, req_ready}, 64'b1000);
        tick();
        #2;
        checkOutput("wrap_grant1", {60'd0, req_ready}, 64'b0010);
        tick();
        applyStimulus(4'b0000);
        for (int c = 0; c < 6; c++) tick();

        // Reset with three issues in flight (pointer 1: grants 0, 3, 2)
        applyStimulus(4'b1111);
        tick();
        tick();
        tick();
        applyStimulus(4'b0000);
        rst = 1'b1;
        #2;
        checkOutput("midreset_fpu_valid", {63'd0, fpu_valid}, 64'd0);
        checkOutput("midreset_ready", {60'd0, req_ready}, 64'd0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #2;
            checkOutput($sformatf("midreset_resp_c%0d", c),
                        {60'd0, resp_valid}, 64'd0);
            if (c == 0) begin
                checkOutput("postreset_fpu_valid", {63'd0, fpu_valid}, 64'd0);
            end
            tick();
        end

        // First grant after reset: pointer 0 picks the highest valid index
        applyStimulus(4'b0110);
        #2;
        checkOutput("postreset_grant", {60'd0, req_ready}, 64'b0100);
        tick();
        applyStimulus(4'b0000);
        for (int c = 0; c < 6; c++) tick();

        // Sparse random traffic against the scoreboard
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pending[i] && cyc < 2950 && $urandom_range(0, 3) == 0) begin
                    pending[i] = 1'b1;
                    setReq(i, OPW'($urandom_range(0, 3)), $urandom, $urandom);
                end
            end
            applyStimulus(pending);
            #2;
            sampleCycle();
            tick();
        end
        checkOutput("random_all_served", {60'd0, pending}, 64'd0);
        checkOutput("random_all_responded", 64'(expId.size()), 64'd0);
        checkOutput("random_fairness", {63'd0, (maxWait <= NREQ - 1)}, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
